hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Watches register usage in ID and EX, destination registers in EX/MEM/WB, taken control transfers in EX and the data-memory handshake in MEM. From these it produces per-stage stall and flush (bubble) controls and EX operand-forwarding selects. It also tracks data-memory wait time with a timeout FSM and keeps saturating stall and flush counters for bring-up.

---
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush/redirect steering,
// EX operand forwarding, dmem timeout FSM and saturating bring-up counters.
//
// state  | meaning
// RUN    | normal issue, no outstanding dmem wait
// WAIT   | dmem access pending, wait_cnt counts consecutive wait cycles
// ERROR  | dmem timed out, pipeline frozen until reset
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wreg,
    input  logic             ex_is_load,
    input  logic [1:0]       ex_branch_type,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_wreg,
    input  logic             wb_wreg,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clear,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             bubble_wb,
    output logic             redirect,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0]       BR_JAL    = 2'd1;
    localparam logic [1:0]       BR_JALR   = 2'd2;
    localparam logic [1:0]       BR_COND   = 2'd3;
    localparam logic [15:0]      TIMEOUT_V = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        mwait, taken, luse, any_stall;
    logic [1:0]  fwd_raw_a, fwd_raw_b;

    assign mwait = mem_req & ~dmem_ready;
    assign taken = (ex_branch_type == BR_JAL) | (ex_branch_type == BR_JALR) |
                   ((ex_branch_type == BR_COND) & ex_branch_taken);
    assign luse  = ex_is_load & ex_wreg & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // MEM result is younger than WB, so it wins when both match
    assign fwd_raw_a = (mem_wreg & (mem_rd != 5'd0) & (mem_rd == ex_rs1)) ? 2'b01 :
                       (wb_wreg  & (wb_rd  != 5'd0) & (wb_rd  == ex_rs1)) ? 2'b10 : 2'b00;
    assign fwd_raw_b = (mem_wreg & (mem_rd != 5'd0) & (mem_rd == ex_rs2)) ? 2'b01 :
                       (wb_wreg  & (wb_rd  != 5'd0) & (wb_rd  == ex_rs2)) ? 2'b10 : 2'b00;

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state    <= ST_RUN;
            wait_cnt <= 16'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ST_ERROR) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mwait) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            ST_WAIT: begin
                if (!mwait) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt = ST_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        bubble_wb = 1'b0;
        redirect  = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        if (!nReset) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            bubble_wb = 1'b1;
        end else begin
            fwd_a = fwd_raw_a;
            fwd_b = fwd_raw_b;
            if ((state == ST_ERROR) || mwait) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (taken) begin
                // squashed ID instruction makes any load-use moot
                redirect = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (luse) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    assign any_stall = stall_if | stall_id | stall_ex | stall_mem;

    always_ff @(posedge clock) begin
        if (!nReset || cnt_clear) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (any_stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (redirect && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned TMO   = 4;
    localparam int unsigned CW    = 4;
    localparam int          CMAX  = (1 << CW) - 1;

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       id_use_rs1, id_use_rs2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_wreg, ex_is_load;
        logic [1:0] bt;
        logic       btaken;
        logic [4:0] mem_rd, wb_rd;
        logic       mem_wreg, wb_wreg, mem_req, dmem_ready, cnt_clear, rst_n;
    } stim_t;

    typedef struct packed {
        logic          stall_if, stall_id, stall_ex, stall_mem;
        logic          flush_id, flush_ex, bubble_wb, redirect;
        logic [1:0]    fwd_a, fwd_b;
        logic          mem_err;
        logic [CW-1:0] stall_cnt, flush_cnt;
    } resp_t;

    logic          clock = 1'b0;
    logic          nReset;
    logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, ex_wreg, ex_is_load, ex_branch_taken;
    logic [1:0]    ex_branch_type;
    logic          mem_wreg, wb_wreg, mem_req, dmem_ready, cnt_clear;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          flush_id, flush_ex, bubble_wb, redirect, mem_err;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clock(clock), .nReset(nReset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wreg(ex_wreg),
        .ex_is_load(ex_is_load), .ex_branch_type(ex_branch_type),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_wreg(mem_wreg), .wb_wreg(wb_wreg), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .cnt_clear(cnt_clear),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb),
        .redirect(redirect), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    resp_t exp_q[$];
    int    idx_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // model state
    bit    m_err   = 1'b0;
    int    m_run   = 0;
    int    m_scnt  = 0;
    int    m_fcnt  = 0;
    bit    have_prev = 1'b0;
    stim_t prev;
    resp_t prev_exp;

    function automatic stim_t idle();
        stim_t s;
        s.id_rs1 = 5'd0; s.id_rs2 = 5'd0; s.id_use_rs1 = 1'b0; s.id_use_rs2 = 1'b0;
        s.ex_rs1 = 5'd0; s.ex_rs2 = 5'd0; s.ex_rd = 5'd0; s.ex_wreg = 1'b0;
        s.ex_is_load = 1'b0; s.bt = 2'd0; s.btaken = 1'b0;
        s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.mem_wreg = 1'b0; s.wb_wreg = 1'b0;
        s.mem_req = 1'b0; s.dmem_ready = 1'b0; s.cnt_clear = 1'b0; s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] fwd_of(input stim_t s, input logic [4:0] src);
        if (s.mem_wreg && s.mem_rd != 0 && s.mem_rd == src) return 2'b01;
        if (s.wb_wreg && s.wb_rd != 0 && s.wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic resp_t predict(input stim_t s);
        resp_t r;
        bit mw, tk, lu;
        r = '0;
        r.mem_err   = m_err;
        r.stall_cnt = CW'(m_scnt);
        r.flush_cnt = CW'(m_fcnt);
        if (!s.rst_n) begin
            r.flush_id = 1'b1; r.flush_ex = 1'b1; r.bubble_wb = 1'b1;
            return r;
        end
        r.fwd_a = fwd_of(s, s.ex_rs1);
        r.fwd_b = fwd_of(s, s.ex_rs2);
        mw = s.mem_req && !s.dmem_ready;
        tk = (s.bt == 2'd1) || (s.bt == 2'd2) || (s.bt == 2'd3 && s.btaken);
        lu = s.ex_is_load && s.ex_wreg && s.ex_rd != 0 &&
             ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
        if (m_err || mw) begin
            r.stall_if = 1'b1; r.stall_id = 1'b1; r.stall_ex = 1'b1; r.stall_mem = 1'b1;
            r.bubble_wb = 1'b1;
        end else if (tk) begin
            r.redirect = 1'b1; r.flush_id = 1'b1; r.flush_ex = 1'b1;
        end else if (lu) begin
            r.stall_if = 1'b1; r.stall_id = 1'b1; r.flush_ex = 1'b1;
        end
        return r;
    endfunction

    // fold the previous cycle's inputs into the model (the clock edge just happened)
    task automatic advance_model();
        bit mw;
        if (!have_prev) return;
        if (!prev.rst_n) begin
            m_err = 1'b0; m_run = 0; m_scnt = 0; m_fcnt = 0;
            return;
        end
        mw = prev.mem_req && !prev.dmem_ready;
        if (!m_err) begin
            if (mw) begin
                m_run++;
                if (m_run > int'(TMO)) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        if (prev.cnt_clear) begin
            m_scnt = 0; m_fcnt = 0;
        end else begin
            if ((prev_exp.stall_if || prev_exp.stall_id || prev_exp.stall_ex || prev_exp.stall_mem)
                && m_scnt < CMAX) m_scnt++;
            if (prev_exp.redirect && m_fcnt < CMAX) m_fcnt++;
        end
    endtask

    task automatic drive(input stim_t s);
        nReset = s.rst_n;
        id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2;
        ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd; ex_wreg = s.ex_wreg;
        ex_is_load = s.ex_is_load; ex_branch_type = s.bt; ex_branch_taken = s.btaken;
        mem_rd = s.mem_rd; wb_rd = s.wb_rd; mem_wreg = s.mem_wreg; wb_wreg = s.wb_wreg;
        mem_req = s.mem_req; dmem_ready = s.dmem_ready; cnt_clear = s.cnt_clear;
    endtask

    task automatic apply(input stim_t s);
        resp_t e;
        @(posedge clock);
        #1;
        advance_model();
        drive(s);
        e = predict(s);
        exp_q.push_back(e);
        idx_q.push_back(vectors);
        vectors++;
        prev = s;
        prev_exp = e;
        have_prev = 1'b1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s vector %0d: got %0h expected %0h", name, idx, got, want);
        end
    endtask

    // monitor: outputs are present every cycle, sampled mid-cycle
    initial begin
        resp_t e;
        int    idx;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                idx = idx_q.pop_front();
                chk("stall_if",  idx, 32'(stall_if),  32'(e.stall_if));
                chk("stall_id",  idx, 32'(stall_id),  32'(e.stall_id));
                chk("stall_ex",  idx, 32'(stall_ex),  32'(e.stall_ex));
                chk("stall_mem", idx, 32'(stall_mem), 32'(e.stall_mem));
                chk("flush_id",  idx, 32'(flush_id),  32'(e.flush_id));
                chk("flush_ex",  idx, 32'(flush_ex),  32'(e.flush_ex));
                chk("bubble_wb", idx, 32'(bubble_wb), 32'(e.bubble_wb));
                chk("redirect",  idx, 32'(redirect),  32'(e.redirect));
                chk("fwd_a",     idx, 32'(fwd_a),     32'(e.fwd_a));
                chk("fwd_b",     idx, 32'(fwd_b),     32'(e.fwd_b));
                chk("mem_err",   idx, 32'(mem_err),   32'(e.mem_err));
                chk("stall_cnt", idx, 32'(stall_cnt), 32'(e.stall_cnt));
                chk("flush_cnt", idx, 32'(flush_cnt), 32'(e.flush_cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, lu;
        drive(idle());
        nReset = 1'b0;
        repeat (2) @(posedge clock);

        // reset state
        s = idle(); s.rst_n = 1'b0;
        apply(s);

        // load-use then forward from MEM
        lu = idle();
        lu.ex_is_load = 1'b1; lu.ex_wreg = 1'b1; lu.ex_rd = 5'd5;
        lu.id_rs2 = 5'd5; lu.id_use_rs2 = 1'b1;
        apply(lu);
        s = idle(); s.mem_rd = 5'd5; s.mem_wreg = 1'b1; s.ex_rs2 = 5'd5;
        apply(s);

        // forwarding priority
        s = idle(); s.mem_rd = 5'd7; s.wb_rd = 5'd7; s.ex_rs1 = 5'd7;
        s.mem_wreg = 1'b1; s.wb_wreg = 1'b1;
        apply(s);
        s.mem_wreg = 1'b0;
        apply(s);
        s.mem_wreg = 1'b1; s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.ex_rs1 = 5'd0;
        apply(s);

        // redirect overrides load-use
        s = lu; s.bt = 2'd3; s.btaken = 1'b1;
        apply(s);
        apply(idle());

        // 3 wait cycles with pending JAL, redirect only once released
        s = idle(); s.mem_req = 1'b1; s.bt = 2'd1;
        repeat (3) apply(s);
        s.dmem_ready = 1'b1;
        apply(s);
        apply(idle());

        // timeout, sticky error, reset recovery
        s = idle(); s.mem_req = 1'b1;
        repeat (7) apply(s);
        s.dmem_ready = 1'b1;
        repeat (2) apply(s);
        s = idle(); s.rst_n = 1'b0;
        apply(s);
        repeat (2) apply(idle());

        // counter saturation, clear beats increment
        repeat (20) apply(lu);
        s = lu; s.cnt_clear = 1'b1;
        apply(s);
        apply(idle());

        // random traffic biased toward register collisions
        for (int i = 0; i < 3000; i++) begin
            s.id_rs1     = 5'($urandom_range(0, 3));
            s.id_rs2     = 5'($urandom_range(0, 3));
            s.id_use_rs1 = 1'($urandom_range(0, 1));
            s.id_use_rs2 = 1'($urandom_range(0, 1));
            s.ex_rs1     = 5'($urandom_range(0, 3));
            s.ex_rs2     = 5'($urandom_range(0, 3));
            s.ex_rd      = 5'($urandom_range(0, 3));
            s.ex_wreg    = 1'($urandom_range(0, 1));
            s.ex_is_load = 1'($urandom_range(0, 1));
            s.bt         = ($urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(1, 3));
            s.btaken     = 1'($urandom_range(0, 1));
            s.mem_rd     = 5'($urandom_range(0, 3));
            s.wb_rd      = 5'($urandom_range(0, 3));
            s.mem_wreg   = 1'($urandom_range(0, 1));
            s.wb_wreg    = 1'($urandom_range(0, 1));
            s.mem_req    = ($urandom_range(0, 99) < 40);
            s.dmem_ready = ($urandom_range(0, 99) < 50);
            s.cnt_clear  = ($urandom_range(0, 99) < 4);
            s.rst_n      = !($urandom_range(0, 99) < 2);
            apply(s);
        end

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked responses expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
